btb_update_ctrl: RTL
====================

Name: btb_update_ctrl

Overview:
- Sits between the execute-stage branch resolution logic and the branch predictor's BTB update port (update_en / update_pc / update_target).
- Detects mispredictions and issues a one-cycle fetch redirect, then suppresses wrong-path resolutions for a fixed flush window.
- Queues BTB training writes in a small coalescing FIFO and drains them one per cycle, whenever the fetch side does not block the port.

Parameters:
- DEPTH, 4, update queue entries (power of 2, ≥2)
- FLUSH_CYCLES, 2, cycles after a redirect during which res_valid is ignored (≥1)
- XLEN, 32, address width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- res_valid  in  1  EX branch resolution valid
- res_pc  in  XLEN  branch PC
- res_taken  in  1  actual outcome
- res_target  in  XLEN  actual taken target
- res_pred_taken  in  1  prediction carried down the pipe
- res_pred_target  in  XLEN  predicted target carried down the pipe
- upd_block  in  1  fetch holds the BTB write port this cycle
- redirect_valid  out  1  one-cycle redirect pulse to fetch
- redirect_pc  out  XLEN  corrected fetch PC
- flushing  out  1  high while in FLUSH state
- update_en  out  1  BTB write strobe
- update_pc  out  XLEN  BTB write PC
- update_target  out  XLEN  BTB write target
- q_count  out  $clog2(DEPTH)+1  queue occupancy
- drop_count  out  16  saturating count of dropped updates

Behaviour:
- Reset (async, rst_n low): every output is 0, the FSM is in RUN, the queue is empty, and the flush counter is 0. Reset asserted mid-drain or mid-flush discards all state immediately.
- Accepted resolution: res_valid && state==RUN. In FLUSH, res_valid is ignored entirely (no redirect, no enqueue).
- Mispredict, evaluated on an accepted resolution:
  - mis = (res_taken != res_pred_taken) || (res_taken && res_pred_taken && res_target != res_pred_target)
- Redirect:
  - An accepted mispredict at edge N drives redirect_valid=1 for exactly cycle N+1.
  - redirect_pc = res_taken ? res_target : res_pc + 4 (mod 2^XLEN; wrap-around is allowed).
  - Otherwise redirect_valid=0 and redirect_pc holds its last value.
- FSM:
  - RUN -> FLUSH on an accepted mispredict, loading the counter with FLUSH_CYCLES.
  - FLUSH decrements the counter each cycle and returns to RUN when the counter reaches 1.
  - flushing=1 exactly during the FLUSH cycles. The redirect cycle is the first FLUSH cycle.
- Enqueue condition: an accepted resolution with res_taken && mis. Not-taken branches never train the BTB. Correctly predicted taken branches never train the BTB.
- Coalescing:
  - If a queued entry (excluding the head being dequeued this cycle) has the same pc, its target is overwritten with res_target.
  - No new entry is created and the queue order is unchanged.
- Full queue:
  - Full with no coalesce match and no dequeue this cycle: the request is dropped and drop_count increments (saturates at 0xFFFF).
  - Full with a dequeue in the same cycle: the request is accepted.
- Drain:
  - When the queue is non-empty and upd_block=0, the head is popped at the edge.
  - update_en=1 in the following cycle with that entry's pc and target, so all BTB write outputs are registered.
  - At most one write per cycle. update_en=0 otherwise; update_pc and update_target hold their values.
- Latency: an enqueue at edge N into an empty queue, with upd_block=0, gives update_en in cycle N+2 (pop at edge N+1).
- Simultaneous events: enqueue and dequeue in the same cycle leave q_count unchanged. Draining continues during FLUSH.
- upd_block held high: the queue fills and drops are counted. No timeout.

Decomposition:
- Package btb_ctrl_pkg:
  - state enum {RUN, FLUSH}
  - queue entry struct {pc, target}
  - PC_INC = 4
- Sub-module btb_upd_fifo: a DEPTH-entry circular FIFO with head/tail pointers, a CAM-style pc match port with a target-overwrite write, and full/empty/count outputs.
- The top level holds the mispredict compare, the FSM, the redirect registers and drop_count.

Test Plan:
- Cold miss: res_pc=0x1000, taken=1, target=0x2000, pred_taken=0 -> redirect_valid one cycle with redirect_pc=0x2000; flushing for 2 cycles; update_en with 0x1000->0x2000 two cycles after the resolution.
- Target mismatch and not-taken recovery:
  - pred_taken=1, pred_target=0x2000, actual target=0x2100 at pc 0x1000 -> redirect 0x2100 and update 0x1000->0x2100.
  - Separately, pred_taken=1 with actual not-taken at pc 0x3000 -> redirect 0x3004 and no update.
- Flush suppression: a mispredict followed by res_valid mispredicts on the next 2 cycles -> only one redirect pulse and one enqueue.
- Coalesce/full: with upd_block=1, enqueue pcs 0x6000, 0x6004, 0x6008, 0x600C, then 0x6004 with target 0x9000, then 0x6010 -> q_count=4, the 0x6004 entry has target 0x9000, drop_count=1. Release upd_block -> 4 writes on consecutive cycles in FIFO order.
- Reset mid-operation: rst_n low while the queue holds 3 entries and FSM=FLUSH -> all outputs 0 asynchronously; after release, no stale update_en.
- Wrap: res_pc=0xFFFFFFFC with actual not-taken and pred_taken=1 -> redirect_pc=0x00000000.

Source files
------------

// File: rtl/btb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : btb_ctrl_pkg
//  Purpose  : Shared types and constants for the BTB update controller.
//             - state_t     : controller FSM states (RUN / FLUSH)
//             - btb_entry_t : one queued BTB training write {pc, target}
//                             at the default 32-bit address width
//             - PC_INC      : sequential fetch increment
//  Revision : 1.0  initial release
// ============================================================================
package btb_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam int unsigned XLEN_DEFAULT = 32;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] target;
    } btb_entry_t;

    localparam int unsigned PC_INC = 4;

endpackage
`default_nettype wire

// File: rtl/btb_upd_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : btb_upd_fifo
//  Purpose  : DEPTH-entry circular FIFO of BTB training writes with a
//             CAM-style pc lookup. A hit lets the caller overwrite the
//             matching entry's target in place instead of pushing.
//  Ports    : clk, rst_n        clock / async active-low reset
//             push, pop         enqueue wr_entry / dequeue head
//             ovr               overwrite target of every matching entry
//             wr_entry          entry being enqueued / looked up
//             match             wr_entry.pc hits a live entry (the head is
//                               excluded while it is being popped)
//             full, empty,count occupancy status
//             head              entry at the head pointer
//  Revision : 1.0  initial release
// ============================================================================
module btb_upd_fifo
    import btb_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         ENTRY_T = btb_entry_t
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       ovr,
    input  ENTRY_T                     wr_entry,
    output logic                       match,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output ENTRY_T                     head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    ENTRY_T             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic [DEPTH-1:0]   w_hit;

    // An entry is live when its distance from the head is below the count.
    // The head is not a coalescing candidate in the cycle it leaves the queue.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cam
            logic [PTR_W-1:0] w_ofs;
            assign w_ofs     = PTR_W'(gi) - r_head;
            assign w_hit[gi] = ({1'b0, w_ofs} < r_count)
                             && !(pop && (w_ofs == '0))
                             && (r_mem[gi].pc == wr_entry.pc);
        end
    endgenerate

    assign match = |w_hit;
    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign head  = r_mem[r_head];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            if (push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Storage carries no reset: liveness is defined purely by the pointers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (ovr && w_hit[i]) begin
                r_mem[i].target <= wr_entry.target;
            end
        end
        if (push) begin
            r_mem[r_tail] <= wr_entry;
        end
    end

endmodule
`default_nettype wire

// File: rtl/btb_update_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : btb_update_ctrl
//  Purpose  : Between EX branch resolution and the BTB update port.
//             Detects mispredicts, pulses a one-cycle fetch redirect,
//             ignores wrong-path resolutions for FLUSH_CYCLES cycles, and
//             queues taken-branch training writes in a coalescing FIFO that
//             drains one write per cycle while upd_block is low.
//  Ports    : clk, rst_n                        clock / async active-low reset
//             res_valid/pc/taken/target         EX resolution
//             res_pred_taken/res_pred_target    prediction carried down pipe
//             upd_block                         fetch owns the BTB port
//             redirect_valid/redirect_pc        redirect to fetch
//             flushing                          FSM is in FLUSH
//             update_en/pc/target               registered BTB write
//             q_count                           queue occupancy
//             drop_count                        saturating drop counter
//  Revision : 1.0  initial release
// ============================================================================
module btb_update_ctrl
    import btb_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned XLEN         = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    res_valid,
    input  logic [XLEN-1:0]         res_pc,
    input  logic                    res_taken,
    input  logic [XLEN-1:0]         res_target,
    input  logic                    res_pred_taken,
    input  logic [XLEN-1:0]         res_pred_target,
    input  logic                    upd_block,
    output logic                    redirect_valid,
    output logic [XLEN-1:0]         redirect_pc,
    output logic                    flushing,
    output logic                    update_en,
    output logic [XLEN-1:0]         update_pc,
    output logic [XLEN-1:0]         update_target,
    output logic [$clog2(DEPTH):0]  q_count,
    output logic [15:0]             drop_count
);

    localparam int unsigned FCNT_W = $clog2(FLUSH_CYCLES + 1);

    // Same layout as btb_entry_t, sized to this instance's address width.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
    } entry_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [FCNT_W-1:0]  r_flush_cnt;
    logic [FCNT_W-1:0]  w_flush_cnt_nxt;

    logic               w_accept;
    logic               w_mis;
    logic               w_enq;
    logic               w_pop;
    logic               w_push;
    logic               w_ovr;
    logic               w_drop;
    logic               w_match;
    logic               w_full;
    logic               w_empty;
    entry_t             w_wr_entry;
    entry_t             w_head;

    logic               r_redirect_valid;
    logic [XLEN-1:0]    r_redirect_pc;
    logic               r_update_en;
    logic [XLEN-1:0]    r_update_pc;
    logic [XLEN-1:0]    r_update_target;
    logic [15:0]        r_drop_count;

    assign w_accept = res_valid && (r_state == RUN);
    assign w_mis    = (res_taken != res_pred_taken)
                    || (res_taken && res_pred_taken && (res_target != res_pred_target));

    // Only taken mispredicts train the BTB.
    assign w_enq    = w_accept && res_taken && w_mis;
    assign w_pop    = !w_empty && !upd_block;
    assign w_ovr    = w_enq && w_match;
    // A full queue still accepts when its head leaves in the same cycle.
    assign w_push   = w_enq && !w_match && (!w_full || w_pop);
    assign w_drop   = w_enq && !w_match && w_full && !w_pop;

    assign w_wr_entry = '{pc: res_pc, target: res_target};

    btb_upd_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_T (entry_t)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (w_push),
        .pop      (w_pop),
        .ovr      (w_ovr),
        .wr_entry (w_wr_entry),
        .match    (w_match),
        .full     (w_full),
        .empty    (w_empty),
        .count    (q_count),
        .head     (w_head)
    );

    // The redirect cycle is the first FLUSH cycle; leaving on count==1
    // gives exactly FLUSH_CYCLES cycles in FLUSH.
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        case (r_state)
            RUN: begin
                if (w_accept && w_mis) begin
                    w_state_nxt     = FLUSH;
                    w_flush_cnt_nxt = FCNT_W'(FLUSH_CYCLES);
                end
            end
            FLUSH: begin
                if (r_flush_cnt == FCNT_W'(1)) begin
                    w_state_nxt     = RUN;
                    w_flush_cnt_nxt = '0;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - FCNT_W'(1);
                end
            end
            default: begin
                w_state_nxt     = RUN;
                w_flush_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_update_en      <= 1'b0;
            r_update_pc      <= '0;
            r_update_target  <= '0;
            r_drop_count     <= '0;
        end else begin
            r_redirect_valid <= w_accept && w_mis;
            if (w_accept && w_mis) begin
                r_redirect_pc <= res_taken ? res_target : (res_pc + XLEN'(PC_INC));
            end
            r_update_en <= w_pop;
            if (w_pop) begin
                r_update_pc     <= w_head.pc;
                r_update_target <= w_head.target;
            end
            if (w_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign flushing       = (r_state == FLUSH);
    assign update_en      = r_update_en;
    assign update_pc      = r_update_pc;
    assign update_target  = r_update_target;
    assign drop_count     = r_drop_count;

endmodule
`default_nettype wire
